// File: rtl/noc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | noc_pkg : flit encodings, port codes and field offsets for the NoC  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package noc_pkg;

  localparam logic [2:0] FLIT_ID_HEADER = 3'b001;
  localparam logic [2:0] FLIT_ID_BODY   = 3'b010;
  localparam logic [2:0] FLIT_ID_TAIL   = 3'b100;

  // One-hot router port codes shared with the arbiter and crossbar.
  localparam logic [5:0] IDLE = 6'b000001;
  localparam logic [5:0] L    = 6'b000010;
  localparam logic [5:0] N    = 6'b000100;
  localparam logic [5:0] E    = 6'b001000;
  localparam logic [5:0] W    = 6'b010000;
  localparam logic [5:0] S    = 6'b100000;

  localparam int FLIT_ID_W = 3;
  localparam int LEN_LSB   = 0;
  localparam int LEN_W     = 12;

  typedef enum logic [0:0] {
    FRAME_IDLE   = 1'b0,
    FRAME_IN_PKT = 1'b1
  } frame_state_e;

  // flit_id sits in the top FLIT_ID_W bits of a flit of the given width.
  function automatic int flit_id_lsb(input int flit_width);
    return flit_width - FLIT_ID_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_input_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | noc_input_buffer_if : link-side and arbiter-side buffer signals     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface noc_input_buffer_if #(
  parameter int FLIT_WIDTH = 32
) ();
  import noc_pkg::*;

  logic                  in_valid;
  logic [FLIT_WIDTH-1:0] in_flit;
  logic                  in_ready;
  logic                  rd_en;
  logic [FLIT_WIDTH-1:0] out_flit;
  logic [FLIT_ID_W-1:0]  flit_id;
  logic [LEN_W-1:0]      length;
  logic                  req;
  logic                  frame_err;

  modport master (
    output in_valid, in_flit, rd_en,
    input  in_ready, out_flit, flit_id, length, req, frame_err
  );

  modport slave (
    input  in_valid, in_flit, rd_en,
    output in_ready, out_flit, flit_id, length, req, frame_err
  );

endinterface
`default_nettype wire

// File: rtl/noc_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | noc_fifo : generic first-word-fall-through FIFO, power-of-two depth |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module noc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_full, w_empty, w_do_push, w_do_pop;

  assign w_full    = (count_q == CNT_W'(DEPTH));
  assign w_empty   = (count_q == '0);
  assign w_do_push = push_i & ~w_full;
  assign w_do_pop  = pop_i & ~w_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are never visible past the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/noc_input_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | noc_input_buffer : per-port framing check and FWFT flit buffer      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module noc_input_buffer
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst,
  noc_input_buffer_if.slave bus
);

  localparam int ID_LSB = flit_id_lsb(FLIT_WIDTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  frame_state_e          state_q, state_d;
  logic                  frame_err_q, frame_err_d;
  logic [LEN_W-1:0]      length_q, length_d;

  logic [FLIT_ID_W-1:0]  w_in_id;
  logic [FLIT_ID_W-1:0]  w_head_id;
  logic [FLIT_WIDTH-1:0] w_head;
  logic [LEN_W-1:0]      w_head_len;
  logic                  w_full, w_empty;
  logic                  w_in_ready, w_accept, w_push, w_pop, w_err_set;
  logic                  w_head_is_hdr;
  logic [CNT_W-1:0]      w_count_unused;

  noc_fifo #(
    .WIDTH (FLIT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (bus.rd_en),
    .wdata_i (bus.in_flit),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count_unused)
  );

  // Held low while rst is asserted so the link sees no credit during reset.
  assign w_in_ready = rst & ~w_full;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_in_id    = bus.in_flit[FLIT_WIDTH-1:ID_LSB];
  assign w_pop      = bus.rd_en & ~w_empty;

  assign w_head_id     = w_head[FLIT_WIDTH-1:ID_LSB];
  assign w_head_len    = w_head[LEN_LSB +: LEN_W];
  assign w_head_is_hdr = ~w_empty & (w_head_id == FLIT_ID_HEADER);

  // Badly framed flits are consumed from the link but never written.
  always_comb begin
    state_d   = state_q;
    w_push    = 1'b0;
    w_err_set = 1'b0;
    if (w_accept) begin
      unique case (state_q)
        FRAME_IDLE: begin
          if (w_in_id == FLIT_ID_HEADER) begin
            w_push  = 1'b1;
            state_d = FRAME_IN_PKT;
          end else begin
            w_err_set = 1'b1;
          end
        end
        FRAME_IN_PKT: begin
          if (w_in_id == FLIT_ID_BODY) begin
            w_push = 1'b1;
          end else if (w_in_id == FLIT_ID_TAIL) begin
            w_push  = 1'b1;
            state_d = FRAME_IDLE;
          end else begin
            w_err_set = 1'b1;
          end
        end
        default: state_d = FRAME_IDLE;
      endcase
    end
  end

  assign frame_err_d = frame_err_q | w_err_set;
  assign length_d    = (w_pop && w_head_is_hdr) ? w_head_len : length_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FRAME_IDLE;
      frame_err_q <= 1'b0;
      length_q    <= '0;
    end else begin
      state_q     <= state_d;
      frame_err_q <= frame_err_d;
      length_q    <= length_d;
    end
  end

  // Header length bypasses length_q so the arbiter timer can load it before the pop.
  assign bus.in_ready  = w_in_ready;
  assign bus.req       = ~w_empty;
  assign bus.out_flit  = w_empty ? '0 : w_head;
  assign bus.flit_id   = w_empty ? '0 : w_head_id;
  assign bus.length    = w_head_is_hdr ? w_head_len : length_q;
  assign bus.frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_noc_input_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_noc_input_buffer : directed and random checks against a queue    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_noc_input_buffer;
  import noc_pkg::*;

  localparam int FW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_input_buffer_if #(.FLIT_WIDTH(FW)) bus ();

  noc_input_buffer #(
    .FLIT_WIDTH (FW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: packet-level queue of stored flits plus framing flags.
  logic [FW-1:0] mq[$];
  bit            m_in_pkt;
  bit            m_err;
  bit            m_in_reset;
  logic [11:0]   m_len;
  logic [2:0]    bad_ids [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

  function automatic logic [FW-1:0] mk(input logic [2:0] id, input logic [28:0] pl);
    return {id, pl};
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_in_pkt   = 1'b0;
    m_err      = 1'b0;
    m_len      = 12'h000;
    m_in_reset = 1'b1;
  endfunction

  function automatic void m_tick(input bit v, input logic [FW-1:0] f, input bit r);
    bit            rdy;
    logic [2:0]    id;
    logic [FW-1:0] head;
    if (m_in_reset) return;
    rdy = (mq.size() < DEPTH);
    if (r && mq.size() != 0) begin
      head = mq.pop_front();
      if (head[31:29] == FLIT_ID_HEADER) m_len = head[11:0];
    end
    if (v && rdy) begin
      id = f[31:29];
      if (!m_in_pkt) begin
        if (id == FLIT_ID_HEADER) begin mq.push_back(f); m_in_pkt = 1'b1; end
        else m_err = 1'b1;
      end else if (id == FLIT_ID_BODY) begin
        mq.push_back(f);
      end else if (id == FLIT_ID_TAIL) begin
        mq.push_back(f); m_in_pkt = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
  endfunction

  function automatic logic e_ready();
    return !m_in_reset && (mq.size() < DEPTH);
  endfunction
  function automatic logic e_req();
    return mq.size() != 0;
  endfunction
  function automatic logic [FW-1:0] e_flit();
    return (mq.size() != 0) ? mq[0] : '0;
  endfunction
  function automatic logic [2:0] e_id();
    logic [FW-1:0] h;
    h = e_flit();
    return h[31:29];
  endfunction
  function automatic logic [11:0] e_len();
    logic [FW-1:0] h;
    h = e_flit();
    return (mq.size() != 0 && h[31:29] == FLIT_ID_HEADER) ? h[11:0] : m_len;
  endfunction

  task automatic step(input bit v, input logic [FW-1:0] f, input bit r);
    bus.in_valid = v;
    bus.in_flit  = f;
    bus.rd_en    = r;
    @(posedge clk);
    m_tick(v, f, r);
    #1;
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_in_reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_flit = '0; bus.rd_en = 1'b0;
    #2;
    rst = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL rst_in_ready: got %0h expected 0", bus.in_ready); end
    n_checks++; if (bus.req !== 1'b0) begin n_errors++; $display("FAIL rst_req: got %0h expected 0", bus.req); end
    n_checks++; if (bus.out_flit !== 32'h0) begin n_errors++; $display("FAIL rst_out_flit: got %h expected 0", bus.out_flit); end
    n_checks++; if (bus.length !== 12'h0) begin n_errors++; $display("FAIL rst_length: got %h expected 0", bus.length); end
    @(negedge clk);
    rst = 1'b1;
    m_in_reset = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL idle_in_ready: got %0h expected 1", bus.in_ready); end
    n_checks++; if (bus.req !== 1'b0) begin n_errors++; $display("FAIL idle_req: got %0h expected 0", bus.req); end
    n_checks++; if (bus.flit_id !== 3'b000) begin n_errors++; $display("FAIL idle_flit_id: got %b expected 000", bus.flit_id); end
    n_checks++; if (bus.frame_err !== 1'b0) begin n_errors++; $display("FAIL idle_frame_err: got %0h expected 0", bus.frame_err); end
  endtask

  task automatic test_single_packet();
    logic [FW-1:0] h, b, t;
    h = mk(FLIT_ID_HEADER, {17'($urandom), 12'h00A});
    b = mk(FLIT_ID_BODY, 29'($urandom));
    t = mk(FLIT_ID_TAIL, 29'($urandom));
    step(1'b1, h, 1'b0);
    n_checks++; if (bus.req !== 1'b1) begin n_errors++; $display("FAIL pkt_req: got %0h expected 1", bus.req); end
    n_checks++; if (bus.flit_id !== 3'b001) begin n_errors++; $display("FAIL pkt_hdr_id: got %b expected 001", bus.flit_id); end
    n_checks++; if (bus.length !== 12'h00A) begin n_errors++; $display("FAIL pkt_hdr_len: got %h expected 00a", bus.length); end
    n_checks++; if (bus.out_flit !== h) begin n_errors++; $display("FAIL pkt_hdr_flit: got %h expected %h", bus.out_flit, h); end
    step(1'b1, b, 1'b0);
    step(1'b1, t, 1'b0);
    step(1'b0, '0, 1'b1);
    n_checks++; if (bus.flit_id !== 3'b010) begin n_errors++; $display("FAIL pkt_body_id: got %b expected 010", bus.flit_id); end
    n_checks++; if (bus.length !== 12'h00A) begin n_errors++; $display("FAIL pkt_len_hold: got %h expected 00a", bus.length); end
    n_checks++; if (bus.out_flit !== b) begin n_errors++; $display("FAIL pkt_body_flit: got %h expected %h", bus.out_flit, b); end
    step(1'b0, '0, 1'b1);
    n_checks++; if (bus.out_flit !== t) begin n_errors++; $display("FAIL pkt_tail_flit: got %h expected %h", bus.out_flit, t); end
    step(1'b0, '0, 1'b1);
    n_checks++; if (bus.req !== 1'b0 || bus.flit_id !== 3'b000) begin n_errors++; $display("FAIL pkt_drained: got req=%0h id=%b expected req=0 id=000", bus.req, bus.flit_id); end
  endtask

  task automatic test_full_wrap();
    logic [FW-1:0] f [4];
    logic [FW-1:0] h2, t2;
    logic [FW-1:0] exp_q [4];
    f[0] = mk(FLIT_ID_HEADER, {17'($urandom), 12'h003});
    f[1] = mk(FLIT_ID_BODY, 29'($urandom));
    f[2] = mk(FLIT_ID_BODY, 29'($urandom));
    f[3] = mk(FLIT_ID_TAIL, 29'($urandom));
    h2   = mk(FLIT_ID_HEADER, {17'($urandom), 12'h005});
    t2   = mk(FLIT_ID_TAIL, 29'($urandom));
    for (int i = 0; i < 4; i++) step(1'b1, f[i], 1'b0);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL full_in_ready: got %0h expected 0", bus.in_ready); end
    step(1'b1, h2, 1'b1);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL full_pop_ready: got %0h expected 1", bus.in_ready); end
    n_checks++; if (bus.out_flit !== f[1]) begin n_errors++; $display("FAIL full_pop_head: got %h expected %h", bus.out_flit, f[1]); end
    n_checks++; if (bus.length !== 12'h003) begin n_errors++; $display("FAIL full_len_q: got %h expected 003", bus.length); end
    step(1'b1, h2, 1'b0);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL refill_in_ready: got %0h expected 0", bus.in_ready); end
    step(1'b0, '0, 1'b1);
    step(1'b1, t2, 1'b0);
    exp_q[0] = f[2]; exp_q[1] = f[3]; exp_q[2] = h2; exp_q[3] = t2;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.out_flit !== exp_q[i]) begin n_errors++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, bus.out_flit, exp_q[i]); end
      n_checks++; if (bus.length !== e_len()) begin n_errors++; $display("FAIL wrap_len[%0d]: got %h expected %h", i, bus.length, e_len()); end
      step(1'b0, '0, 1'b1);
    end
    n_checks++; if (bus.req !== 1'b0) begin n_errors++; $display("FAIL wrap_empty: got %0h expected 0", bus.req); end
  endtask

  task automatic test_framing_errors();
    logic [FW-1:0] h, t;
    h = mk(FLIT_ID_HEADER, {17'($urandom), 12'h007});
    t = mk(FLIT_ID_TAIL, 29'($urandom));
    pulse_reset();
    step(1'b1, mk(FLIT_ID_BODY, 29'($urandom)), 1'b0);
    n_checks++; if (bus.frame_err !== 1'b1) begin n_errors++; $display("FAIL ferr_body_idle: got %0h expected 1", bus.frame_err); end
    n_checks++; if (bus.req !== 1'b0) begin n_errors++; $display("FAIL ferr_body_req: got %0h expected 0", bus.req); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL ferr_body_ready: got %0h expected 1", bus.in_ready); end
    step(1'b1, h, 1'b0);
    step(1'b1, mk(FLIT_ID_HEADER, 29'($urandom)), 1'b0);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL ferr_hdr_ready: got %0h expected 1", bus.in_ready); end
    step(1'b1, mk(3'b111, 29'($urandom)), 1'b0);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL ferr_111_ready: got %0h expected 1", bus.in_ready); end
    step(1'b1, t, 1'b0);
    n_checks++; if (bus.out_flit !== h) begin n_errors++; $display("FAIL ferr_head: got %h expected %h", bus.out_flit, h); end
    step(1'b0, '0, 1'b1);
    n_checks++; if (bus.out_flit !== t) begin n_errors++; $display("FAIL ferr_next: got %h expected %h", bus.out_flit, t); end
    step(1'b0, '0, 1'b1);
    n_checks++; if (bus.req !== 1'b0) begin n_errors++; $display("FAIL ferr_drained: got %0h expected 0", bus.req); end
    n_checks++; if (bus.frame_err !== 1'b1) begin n_errors++; $display("FAIL ferr_sticky: got %0h expected 1", bus.frame_err); end
  endtask

  task automatic test_underflow_simul();
    logic [FW-1:0] h, b, b2, t;
    h  = mk(FLIT_ID_HEADER, {17'($urandom), 12'h011});
    b  = mk(FLIT_ID_BODY, 29'($urandom));
    b2 = mk(FLIT_ID_BODY, 29'($urandom));
    t  = mk(FLIT_ID_TAIL, 29'($urandom));
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    n_checks++; if (bus.req !== 1'b0 || bus.out_flit !== 32'h0) begin n_errors++; $display("FAIL uflow_state: got req=%0h flit=%h expected 0/0", bus.req, bus.out_flit); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL uflow_ready: got %0h expected 1", bus.in_ready); end
    step(1'b1, h, 1'b0);
    n_checks++; if (bus.out_flit !== h) begin n_errors++; $display("FAIL uflow_ptr: got %h expected %h", bus.out_flit, h); end
    step(1'b1, b, 1'b0);
    step(1'b1, b2, 1'b1);
    n_checks++; if (bus.out_flit !== b) begin n_errors++; $display("FAIL simul_head1: got %h expected %h", bus.out_flit, b); end
    step(1'b1, t, 1'b1);
    n_checks++; if (bus.out_flit !== b2) begin n_errors++; $display("FAIL simul_head2: got %h expected %h", bus.out_flit, b2); end
    step(1'b0, '0, 1'b1);
    n_checks++; if (bus.out_flit !== t) begin n_errors++; $display("FAIL simul_head3: got %h expected %h", bus.out_flit, t); end
    step(1'b0, '0, 1'b1);
    n_checks++; if (bus.req !== 1'b0) begin n_errors++; $display("FAIL simul_count: got %0h expected 0", bus.req); end
  endtask

  task automatic test_reset_mid_packet();
    logic [FW-1:0] h2;
    h2 = mk(FLIT_ID_HEADER, {17'($urandom), 12'h02C});
    step(1'b1, mk(FLIT_ID_HEADER, 29'($urandom)), 1'b0);
    step(1'b1, mk(FLIT_ID_BODY, 29'($urandom)), 1'b0);
    n_checks++; if (bus.req !== 1'b1) begin n_errors++; $display("FAIL mid_pre_req: got %0h expected 1", bus.req); end
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    n_checks++; if (bus.req !== 1'b0) begin n_errors++; $display("FAIL mid_async_req: got %0h expected 0", bus.req); end
    n_checks++; if (bus.in_ready !== 1'b0 || bus.flit_id !== 3'b000) begin n_errors++; $display("FAIL mid_async_out: got ready=%0h id=%b expected 0/000", bus.in_ready, bus.flit_id); end
    n_checks++; if (bus.frame_err !== 1'b0) begin n_errors++; $display("FAIL mid_async_ferr: got %0h expected 0", bus.frame_err); end
    @(negedge clk);
    rst = 1'b1;
    m_in_reset = 1'b0;
    step(1'b1, mk(FLIT_ID_BODY, 29'($urandom)), 1'b0);
    n_checks++; if (bus.frame_err !== 1'b1 || bus.req !== 1'b0) begin n_errors++; $display("FAIL mid_body_drop: got ferr=%0h req=%0h expected 1/0", bus.frame_err, bus.req); end
    step(1'b1, h2, 1'b0);
    n_checks++; if (bus.flit_id !== 3'b001 || bus.length !== 12'h02C) begin n_errors++; $display("FAIL mid_hdr_accept: got id=%b len=%h expected 001/02c", bus.flit_id, bus.length); end
    step(1'b1, mk(FLIT_ID_TAIL, 29'($urandom)), 1'b1);
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    bit            v, r;
    int            sel;
    logic [2:0]    id;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 19);
      if (sel < 5)       id = FLIT_ID_HEADER;
      else if (sel < 12) id = FLIT_ID_BODY;
      else if (sel < 18) id = FLIT_ID_TAIL;
      else               id = bad_ids[$urandom_range(0, 4)];
      r = ((i / 40) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step(v, mk(id, 29'($urandom)), r);
      n_checks++; if (bus.in_ready !== e_ready()) begin n_errors++; $display("FAIL rnd_ready@%0d: got %0h expected %0h", i, bus.in_ready, e_ready()); end
      n_checks++; if (bus.req !== e_req()) begin n_errors++; $display("FAIL rnd_req@%0d: got %0h expected %0h", i, bus.req, e_req()); end
      n_checks++; if (bus.out_flit !== e_flit()) begin n_errors++; $display("FAIL rnd_flit@%0d: got %h expected %h", i, bus.out_flit, e_flit()); end
      n_checks++; if (bus.flit_id !== e_id()) begin n_errors++; $display("FAIL rnd_id@%0d: got %b expected %b", i, bus.flit_id, e_id()); end
      n_checks++; if (bus.length !== e_len()) begin n_errors++; $display("FAIL rnd_len@%0d: got %h expected %h", i, bus.length, e_len()); end
      n_checks++; if (bus.frame_err !== m_err) begin n_errors++; $display("FAIL rnd_ferr@%0d: got %0h expected %0h", i, bus.frame_err, m_err); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_packet();
    test_full_wrap();
    test_framing_errors();
    test_underflow_simul();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
